// File: rtl/pipeline_feeder_pkg.sv
// ============================================================================
// Module      : pipeline_feeder_pkg
// Description : State encodings and sizing helper shared by pipeline_feeder
//               and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_feeder_pkg;

    // Issue-side handshake states
    localparam logic [1:0] c_issue_idle    = 2'd0;
    localparam logic [1:0] c_issue_req     = 2'd1;
    localparam logic [1:0] c_issue_release = 2'd2;

    // Result-side handshake states
    localparam logic [0:0] c_sink_wait_dor = 1'b0;
    localparam logic [0:0] c_sink_acked    = 1'b1;

    // Pointer width for a power-of-two FIFO; never narrower than one bit
    function automatic int fifo_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module      : result_fifo
// Description : Synchronous show-ahead FIFO with occupancy count. The head
//               word reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo
    import pipeline_feeder_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = fifo_ptr_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [PTR_W:0]    o_count
);

    localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && (r_count != c_full_count);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full_count);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written at the tail, no reset needed on the data
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_feeder.sv
// ============================================================================
// Module      : pipeline_feeder
// Description : Fetch-address generator driving the pipeline DIR/ack input
//               handshake with a credit limit and PC redirect, plus a result
//               collector on the DOR/ack output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_feeder
    import pipeline_feeder_pkg::*;
#(
    parameter int               DATA_W       = 32,
    parameter int               PC_STEP      = 4,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int               MAX_INFLIGHT = 4,
    parameter int               FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            redirect_valid,
    input  logic [DATA_W-1:0]               redirect_pc,
    output logic                            pipe_dir,
    output logic [DATA_W-1:0]               pipe_data_in,
    input  logic                            pipe_ack_in,
    input  logic                            pipe_dor,
    input  logic [DATA_W-1:0]               pipe_data_out,
    output logic                            pipe_ack_out,
    output logic                            res_valid,
    output logic [DATA_W-1:0]               res_data,
    input  logic                            res_ready,
    output logic [3:0]                      inflight,
    output logic [fifo_ptr_w(FIFO_DEPTH):0] fifo_count
);

    localparam logic [DATA_W-1:0] c_pc_step      = DATA_W'(PC_STEP);
    localparam logic [3:0]        c_max_inflight = 4'(MAX_INFLIGHT);

    logic [1:0]        r_issue_state, w_issue_next;
    logic              r_pipe_dir, w_dir_next;
    logic [DATA_W-1:0] r_pipe_data_in, w_din_next;
    logic [DATA_W-1:0] r_pc, w_pc_next;
    logic              r_redir_pend, w_pend_next;
    logic [DATA_W-1:0] r_redir_pc, w_pend_pc_next;
    logic              w_issue_done;

    logic [0:0]        r_sink_state, w_sink_next;
    logic              r_ack_out, w_ack_out_next;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    logic [3:0]        r_inflight;

    // Issue next-state: request, hold until ack, then wait for ack release
    always_comb begin
        w_issue_next   = r_issue_state;
        w_dir_next     = r_pipe_dir;
        w_din_next     = r_pipe_data_in;
        w_pc_next      = r_pc;
        w_pend_next    = r_redir_pend;
        w_pend_pc_next = r_redir_pc;
        w_issue_done   = 1'b0;
        case (r_issue_state)
            c_issue_idle: begin
                // A redirect arriving on the issue cycle is issued directly
                if (redirect_valid) w_pc_next = redirect_pc;
                if (enable && (r_inflight < c_max_inflight)) begin
                    w_dir_next   = 1'b1;
                    w_din_next   = redirect_valid ? redirect_pc : r_pc;
                    w_issue_next = c_issue_req;
                end
            end
            c_issue_req: begin
                if (pipe_ack_in) begin
                    w_dir_next   = 1'b0;
                    w_issue_done = 1'b1;
                    w_pend_next  = 1'b0;
                    w_issue_next = c_issue_release;
                    if (redirect_valid)    w_pc_next = redirect_pc;
                    else if (r_redir_pend) w_pc_next = r_redir_pc;
                    else                   w_pc_next = r_pc + c_pc_step;
                end else if (redirect_valid) begin
                    // The bus request stays put; the target waits for the ack
                    w_pend_next    = 1'b1;
                    w_pend_pc_next = redirect_pc;
                end
            end
            c_issue_release: begin
                if (redirect_valid) w_pc_next = redirect_pc;
                if (!pipe_ack_in)   w_issue_next = c_issue_idle;
            end
            default: begin
                w_issue_next = c_issue_idle;
                w_dir_next   = 1'b0;
            end
        endcase
    end

    // Issue state and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_state  <= c_issue_idle;
            r_pipe_dir     <= 1'b0;
            r_pipe_data_in <= '0;
            r_pc           <= RESET_PC;
            r_redir_pend   <= 1'b0;
            r_redir_pc     <= '0;
        end else begin
            r_issue_state  <= w_issue_next;
            r_pipe_dir     <= w_dir_next;
            r_pipe_data_in <= w_din_next;
            r_pc           <= w_pc_next;
            r_redir_pend   <= w_pend_next;
            r_redir_pc     <= w_pend_pc_next;
        end
    end

    // Sink next-state: accept one result when there is room, ack for one cycle
    always_comb begin
        w_sink_next    = r_sink_state;
        w_ack_out_next = r_ack_out;
        w_push         = 1'b0;
        case (r_sink_state)
            c_sink_wait_dor: begin
                if (pipe_dor && !w_fifo_full) begin
                    w_push         = 1'b1;
                    w_ack_out_next = 1'b1;
                    w_sink_next    = c_sink_acked;
                end
            end
            default: begin
                w_ack_out_next = 1'b0;
                w_sink_next    = c_sink_wait_dor;
            end
        endcase
    end

    // Sink state and registered ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sink_state <= c_sink_wait_dor;
            r_ack_out    <= 1'b0;
        end else begin
            r_sink_state <= w_sink_next;
            r_ack_out    <= w_ack_out_next;
        end
    end

    // Outstanding-request credit: issue adds, returned result removes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue_done, w_push})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   if (r_inflight != 4'd0) r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A result with nothing outstanding means the pipeline misbehaved
    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_issue_done) begin
            assert (r_inflight != 4'd0);
        end
    end

    result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (pipe_data_out),
        .i_pop   (res_ready),
        .o_data  (res_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (fifo_count)
    );

    assign pipe_dir     = r_pipe_dir;
    assign pipe_data_in = r_pipe_data_in;
    assign pipe_ack_out = r_ack_out;
    assign res_valid    = !w_fifo_empty;
    assign inflight     = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_feeder.sv
// ============================================================================
// Module      : tb_pipeline_feeder
// Description : Self-checking bench for pipeline_feeder: vector table,
//               directed corner sequences and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_feeder;

    localparam int          DATA_W       = 32;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] RESET_PC     = 32'h0;
    localparam int          MAX_INFLIGHT = 4;
    localparam int          FIFO_DEPTH   = 4;
    localparam int          NV           = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pipe_dir;
    logic [31:0] pipe_data_in;
    logic        pipe_ack_in;
    logic        pipe_dor;
    logic [31:0] pipe_data_out;
    logic        pipe_ack_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic [3:0]  inflight;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int en; int redir; int rpc; int ack; int dor; int dout; int rr;
        int dir; int din; int aout; int infl; int rv; int rd; int cnt;
    } vec_t;
    vec_t vecs [NV];

    pipeline_feeder #(
        .DATA_W       (DATA_W),
        .PC_STEP      (PC_STEP),
        .RESET_PC     (RESET_PC),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pipe_dir       (pipe_dir),
        .pipe_data_in   (pipe_data_in),
        .pipe_ack_in    (pipe_ack_in),
        .pipe_dor       (pipe_dor),
        .pipe_data_out  (pipe_data_out),
        .pipe_ack_out   (pipe_ack_out),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .inflight       (inflight),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        pipe_ack_in = 1'b0; pipe_dor = 1'b0; pipe_data_out = '0; res_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // One full request handshake: wait for DIR, ack, release
    task automatic issue_one(output logic [31:0] pc);
        logic found = 1'b0;
        enable = 1'b1;
        pc = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pipe_dir) begin found = 1'b1; break; end
        end
        check("issue_wait", 64'(found), 64'(1));
        pc = pipe_data_in;
        pipe_ack_in = 1'b1; enable = 1'b0;
        tick();
        pipe_ack_in = 1'b0;
        tick();
    endtask

    // Present one result on DOR until it is acked
    task automatic return_one(input logic [31:0] d);
        logic found = 1'b0;
        pipe_dor = 1'b1; pipe_data_out = d;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (pipe_ack_out) begin found = 1'b1; break; end
        end
        check("return_wait", 64'(found), 64'(1));
        pipe_dor = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        logic        seen;
        // random-phase model state
        logic [31:0] exp_next;
        int          m_infl;
        logic [31:0] pq [$];
        logic [31:0] fq [$];
        logic        p_dir, p_aout, p_ack, p_dor, p_rr, p_en;
        logic [31:0] p_din, p_dout;
        int          sb;
        int          rr_bias;

        //          en rd rpc    ak dr dout  rr | dir din    ao inf rv rd    cnt
        vecs[0]  = '{1, 0, 0,     0, 0, 0,    0,  1, 0,     0, 0,  0, 0,    0};
        vecs[1]  = '{1, 0, 0,     1, 0, 0,    0,  0, 0,     0, 1,  0, 0,    0};
        vecs[2]  = '{1, 0, 0,     0, 0, 0,    0,  0, 0,     0, 1,  0, 0,    0};
        vecs[3]  = '{1, 0, 0,     0, 0, 0,    0,  1, 4,     0, 1,  0, 0,    0};
        vecs[4]  = '{1, 0, 0,     1, 0, 0,    0,  0, 4,     0, 2,  0, 0,    0};
        vecs[5]  = '{1, 0, 0,     0, 0, 0,    0,  0, 4,     0, 2,  0, 0,    0};
        vecs[6]  = '{1, 0, 0,     0, 0, 0,    0,  1, 8,     0, 2,  0, 0,    0};
        vecs[7]  = '{1, 0, 0,     1, 0, 0,    0,  0, 8,     0, 3,  0, 0,    0};
        vecs[8]  = '{1, 0, 0,     0, 0, 0,    0,  0, 8,     0, 3,  0, 0,    0};
        vecs[9]  = '{1, 0, 0,     0, 0, 0,    0,  1, 12,    0, 3,  0, 0,    0};
        vecs[10] = '{1, 0, 0,     1, 0, 0,    0,  0, 12,    0, 4,  0, 0,    0};
        vecs[11] = '{1, 0, 0,     0, 0, 0,    0,  0, 12,    0, 4,  0, 0,    0};
        vecs[12] = '{1, 0, 0,     0, 0, 0,    0,  0, 12,    0, 4,  0, 0,    0};
        vecs[13] = '{1, 0, 0,     0, 1, 'h10, 0,  0, 12,    1, 3,  1, 'h10, 1};
        vecs[14] = '{1, 0, 0,     0, 0, 0,    0,  1, 16,    0, 3,  1, 'h10, 1};
        vecs[15] = '{1, 0, 0,     1, 1, 'h20, 0,  0, 16,    1, 3,  1, 'h10, 2};
        vecs[16] = '{1, 0, 0,     0, 0, 0,    1,  0, 16,    0, 3,  1, 'h20, 1};
        vecs[17] = '{0, 0, 0,     0, 0, 0,    1,  0, 16,    0, 3,  0, 0,    0};
        vecs[18] = '{1, 0, 0,     0, 0, 0,    0,  1, 20,    0, 3,  0, 0,    0};
        vecs[19] = '{1, 1, 'h100, 0, 0, 0,    0,  1, 20,    0, 3,  0, 0,    0};
        vecs[20] = '{1, 0, 0,     1, 1, 'h30, 0,  0, 20,    1, 3,  1, 'h30, 1};
        vecs[21] = '{1, 0, 0,     0, 0, 0,    1,  0, 20,    0, 3,  0, 0,    0};
        vecs[22] = '{1, 0, 0,     0, 0, 0,    0,  1, 'h100, 0, 3,  0, 0,    0};

        // Reset values
        idle_inputs();
        reset = 1'b1;
        tick(); tick(); tick();
        check("reset_dir",   64'(pipe_dir), 64'(0));
        check("reset_din",   64'(pipe_data_in), 64'(0));
        check("reset_ackout",64'(pipe_ack_out), 64'(0));
        check("reset_infl",  64'(inflight), 64'(0));
        check("reset_res",   64'({res_valid, res_data, fifo_count}), 64'(0));
        reset = 1'b0;

        // Vector table: issue sequence, credit stop, results, redirect in REQ
        for (int i = 0; i < NV; i++) begin
            enable         = 1'(vecs[i].en);
            redirect_valid = 1'(vecs[i].redir);
            redirect_pc    = 32'(vecs[i].rpc);
            pipe_ack_in    = 1'(vecs[i].ack);
            pipe_dor       = 1'(vecs[i].dor);
            pipe_data_out  = 32'(vecs[i].dout);
            res_ready      = 1'(vecs[i].rr);
            tick();
            check($sformatf("vec%0d_bus", i),
                  64'({pipe_dir, pipe_data_in, pipe_ack_out, inflight}),
                  64'({1'(vecs[i].dir), 32'(vecs[i].din), 1'(vecs[i].aout), 4'(vecs[i].infl)}));
            check($sformatf("vec%0d_fifo", i),
                  64'({res_valid, res_data, fifo_count}),
                  64'({1'(vecs[i].rv), 32'(vecs[i].rd), 3'(vecs[i].cnt)}));
        end

        // Reset while a request is on the bus
        idle_inputs();
        reset = 1'b1;
        tick();
        check("midreq_reset_outs",
              64'({pipe_dir, pipe_data_in, pipe_ack_out, inflight, res_valid, fifo_count}), 64'(0));
        reset = 1'b0;
        issue_one(pc);
        check("midreq_reset_pc", 64'(pc), 64'(RESET_PC));

        // Redirect in IDLE then PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        issue_one(pc);
        check("wrap_pc_top", 64'(pc), 64'(32'hFFFF_FFFC));
        issue_one(pc);
        check("wrap_pc_zero", 64'(pc), 64'(0));

        // FIFO full back-pressure
        do_reset();
        for (int k = 0; k < 4; k++) issue_one(pc);
        for (int k = 0; k < 4; k++) return_one(32'h40 + 32'(k));
        check("full_count", 64'(fifo_count), 64'(4));
        issue_one(pc);
        pipe_dor = 1'b1; pipe_data_out = 32'h99;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pipe_ack_out) seen = 1'b1;
        end
        check("full_no_ack", 64'(seen), 64'(0));
        check("full_head", 64'(res_data), 64'(32'h40));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (pipe_ack_out) begin seen = 1'b1; break; end
        end
        check("full_pop_ack", 64'(seen), 64'(1));
        pipe_dor = 1'b0;
        tick();

        // Randomized traffic against the reference model
        do_reset();
        exp_next = RESET_PC; m_infl = 0;
        pq.delete(); fq.delete();
        p_dir = 0; p_aout = 0; p_ack = 0; p_dor = 0; p_rr = 0; p_en = 0;
        p_din = '0; p_dout = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            sb = fq.size();
            if (p_rr && fq.size() > 0) void'(fq.pop_front());
            if (pipe_ack_out) begin
                check("rnd_ack_pulse", 64'(p_aout), 64'(0));
                check("rnd_ack_needs_dor", 64'(p_dor), 64'(1));
                check("rnd_ack_not_full", 64'(sb < FIFO_DEPTH), 64'(1));
                fq.push_back(p_dout);
                if (pq.size() > 0) void'(pq.pop_front());
                m_infl--;
            end
            if (p_dir && !pipe_dir) begin
                check("rnd_accept_ack", 64'(p_ack), 64'(1));
                m_infl++;
                pq.push_back(p_din);
            end
            if (!p_dir && pipe_dir) begin
                check("rnd_issue_pc", 64'(pipe_data_in), 64'(exp_next));
                check("rnd_issue_enable", 64'(p_en), 64'(1));
                exp_next = pipe_data_in + 32'(PC_STEP);
            end
            check("rnd_inflight", 64'(inflight), 64'(m_infl));
            check("rnd_credit", 64'(m_infl <= MAX_INFLIGHT), 64'(1));
            check("rnd_count", 64'(fifo_count), 64'(fq.size()));
            check("rnd_valid", 64'(res_valid), 64'(fq.size() > 0));
            if (fq.size() > 0) check("rnd_head", 64'(res_data), 64'(fq[0]));

            // Pipeline side
            if (pipe_ack_in) begin
                if (!pipe_dir && $urandom_range(1, 0) == 1) pipe_ack_in = 1'b0;
            end else if (pipe_dir && $urandom_range(1, 0) == 1) begin
                pipe_ack_in = 1'b1;
            end
            if (pipe_dor) begin
                if (pipe_ack_out) pipe_dor = 1'b0;
            end else if (pq.size() > 0 && $urandom_range(2, 0) != 0) begin
                pipe_dor = 1'b1;
                pipe_data_out = pq[0] ^ 32'hA5A5_0000;
            end
            // Consumer and control side
            rr_bias = ((cyc / 250) % 2 == 1) ? 2 : 8;
            res_ready = ($urandom_range(9, 0) < rr_bias);
            enable = ($urandom_range(7, 0) != 0);
            redirect_valid = ($urandom_range(9, 0) == 0);
            if (redirect_valid) begin
                redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                exp_next = redirect_pc;
            end
            p_dir = pipe_dir; p_din = pipe_data_in; p_aout = pipe_ack_out;
            p_ack = pipe_ack_in; p_dor = pipe_dor; p_dout = pipe_data_out;
            p_rr = res_ready; p_en = enable;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_feeder.md
# pipeline_feeder

Synthesizable, parametrised front-end driver for the instruction pipeline. It generates a sequential fetch-address stream and presents it on the pipeline's DIR/ack input handshake. It collects pipeline results from the DOR/ack output handshake into a result FIFO. It adds three things the bench-level driver lacked: configurable widths and step, an in-flight credit limit, and PC redirect (branch/jump). The block sits between the core's control logic and `pipeline`, replacing the ad-hoc stimulus logic in the top level.

## Interface
- `DATA_W`, 32: width of PC, pipeline data in/out, and result data.
- `PC_STEP`, 4: PC increment per issued request.
- `RESET_PC`, 0: PC value after reset.
- `MAX_INFLIGHT`, 4: maximum issued-but-unreturned requests (1..15).
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, at least 2.

- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: permits new issues.
- `redirect_valid`, in, 1: single-cycle request to load `redirect_pc`.
- `redirect_pc`, in, DATA_W: new PC.
- `pipe_dir`, out, 1: data-in-ready to pipeline.
- `pipe_data_in`, out, DATA_W: PC presented to pipeline.
- `pipe_ack_in`, in, 1: ack from pipeline for `pipe_dir`.
- `pipe_dor`, in, 1: data-out-ready from pipeline.
- `pipe_data_out`, in, DATA_W: pipeline result.
- `pipe_ack_out`, out, 1: ack to pipeline for `pipe_dor`.
- `res_valid`, out, 1: FIFO non-empty.
- `res_data`, out, DATA_W: FIFO head (show-ahead).
- `res_ready`, in, 1: pops the head when `res_valid` is high.
- `inflight`, out, 4: outstanding request count.
- `fifo_count`, out, clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- **Reset values:** all outputs are 0; PC = RESET_PC; issue FSM = IDLE; sink FSM = WAIT_DOR; redirect pending cleared; FIFO empty.
- **Issue FSM**, all outputs registered:
  - IDLE: if `enable && inflight < MAX_INFLIGHT`, then `pipe_dir`<=1, `pipe_data_in`<=PC, go to REQ.
  - REQ: hold `pipe_dir` and `pipe_data_in` stable. On `pipe_ack_in`: `pipe_dir`<=0; PC<=pending redirect target if one is pending, else PC+PC_STEP (mod 2^DATA_W); `inflight`+1; go to RELEASE.
  - RELEASE: wait for `pipe_ack_in`==0, then go to IDLE.
- **Redirect:**
  - In IDLE or RELEASE, `redirect_valid` loads PC directly.
  - In REQ, it is captured into a one-entry pending register and applied at the handshake completion. The request already on the bus is not cancelled.
  - A later redirect overwrites an earlier pending one (latest wins).
  - A redirect coinciding with the ack edge in REQ wins over the increment.
- **Sink FSM:**
  - WAIT_DOR: if `pipe_dor` and FIFO not full, push `pipe_data_out`, `pipe_ack_out`<=1, `inflight`-1, go to ACKED. If the FIFO is full, no ack is given; the pipeline is back-pressured.
  - ACKED: `pipe_ack_out`<=0, go to WAIT_DOR. `pipe_ack_out` is therefore exactly one cycle wide.
- **Counters:** a simultaneous `inflight` increment and decrement leaves the count unchanged. An underflow (result with `inflight`==0) saturates at 0 and is a simulation assertion failure.
- **FIFO:** push and pop in the same cycle are allowed at any occupancy other than full-with-no-pop. Push is never attempted when full.
- **Enable:** deasserting `enable` in REQ does not abort the request; it only blocks the next IDLE→REQ transition.

## Timing
- PC-to-bus latency: 1 cycle from IDLE qualification.
- Issue throughput: 3 cycles per request when the pipeline acks in the first REQ cycle and drops ack in the following cycle.
- Result acceptance: 2 cycles minimum per result. `res_valid` rises the cycle after the push edge.
- Reset asserted mid-handshake drops `pipe_dir` and `pipe_ack_out` on the same edge. The pipeline is reset together with this block.

## Structure
- Package `pipeline_feeder_pkg`: issue-state encodings (IDLE, REQ, RELEASE), sink-state encodings (WAIT_DOR, ACKED), and a helper for FIFO pointer width.
- Sub-module `result_fifo`: synchronous show-ahead FIFO, parametrised by DATA_W and FIFO_DEPTH, with count output.

## Test plan
- **Reset then enable, ack after 1 cycle, ack low 1 cycle later:** `pipe_data_in` sequence 0, 4, 8, 12, one issue per 3 cycles; `inflight` stops at 4 with no results returned.
- **Return results 0x10, 0x20 via DOR:** `pipe_ack_out` is a 1-cycle pulse each; FIFO pops give 0x10 then 0x20; `inflight` goes 4→2 and issue resumes.
- **Redirect to 0x100 during REQ for PC 0x8:** 0x8 completes, next issued PC is 0x100. Redirect in IDLE: next issued PC is 0x100 with no skip.
- **FIFO full (4 entries, `res_ready`=0) while DOR is held:** no `pipe_ack_out`; one pop leads to an ack within 2 cycles.
- **Reset mid-REQ with `pipe_dir`=1:** on the next edge all outputs are 0 and PC equals RESET_PC.
- **PC at 0xFFFFFFFC with PC_STEP=4:** next issued PC wraps to 0x0.
